// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB initiator bridge: one APB SETUP/ACCESS per word transfer,
// AHB data phase stretched until pready, pslverr and non-word sizes become a two-cycle ERROR.
module ahb_apb_bridge #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              hsel,
  input  logic [31:0]       haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic              hresp,
  output logic [DATA_W-1:0] hrdata,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
  } state_t;

  state_t              state_q, state_d, accept_tgt;
  logic                accept, legal, ok_done;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic                psel_q, penable_q, pwrite_q;
  logic                unused_bits;

  assign unused_bits = ^{haddr[31:ADDR_W], htrans[0]};

  always_comb begin
    ok_done    = (state_q == S_ACCESS) & pready & ~pslverr;
    accept     = hsel & htrans[1] & hready &
                 ((state_q == S_IDLE) | ok_done | (state_q == S_ERR2));
    legal      = (hsize == 3'b010);
    accept_tgt = !legal ? S_ERR1 : (hwrite ? S_WDATA : S_SETUP);

    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = accept_tgt;
      S_WDATA:  state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (pready) state_d = pslverr ? S_ERR1 : (accept ? accept_tgt : S_IDLE);
      S_ERR1:   state_d = S_ERR2;
      S_ERR2:   state_d = accept ? accept_tgt : S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    hreadyout = 1'b0;
    case (state_q)
      S_IDLE, S_ERR2: hreadyout = 1'b1;
      S_ACCESS:       hreadyout = pready & ~pslverr;
      default:        hreadyout = 1'b0;
    endcase
    hresp  = (state_q == S_ERR1) | (state_q == S_ERR2);
    hrdata = ((state_q == S_ACCESS) && !pwrite_q) ? prdata : '0;
  end

  // APB strobes follow the next state so psel stays high across ACCESS->SETUP
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= S_IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      psel_q    <= (state_d == S_SETUP) || (state_d == S_ACCESS);
      penable_q <= (state_d == S_ACCESS);
      if (accept && legal) begin
        paddr_q  <= haddr[ADDR_W-1:0];
        pwrite_q <= hwrite;
      end
      if (state_q == S_WDATA) pwdata_q <= hwdata;
    end
  end

  assign paddr   = paddr_q;
  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign pwdata  = pwdata_q;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Bench for ahb_apb_bridge: AHB master tasks, APB completer with stalls/errors,
// and a transaction-level model predicting wait states, responses, data and APB accesses.
module tb_ahb_apb_bridge;

  logic        pclk, presetn, hsel, hwrite, hready, hreadyout, hresp;
  logic [31:0] haddr, hwdata, hrdata, pwdata, prdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [9:0]  paddr;
  logic        psel, penable, pwrite, pready, pslverr;

  ahb_apb_bridge #(.ADDR_W(10), .DATA_W(32)) dut (
    .pclk(pclk), .presetn(presetn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata), .paddr(paddr),
    .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  typedef struct packed {
    logic [9:0]  addr;
    logic        wr;
    logic [31:0] data;
    logic [7:0]  cyc;
  } rec_t;

  int n_pass = 0;
  int n_total = 0;

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  assign hready = hreadyout;

  // ---------------- APB completer ----------------
  function automatic logic [31:0] seed_val(input logic [7:0] i);
    return {i, ~i, 8'h5A, i};
  endfunction

  logic [31:0] dev_mem [256];
  logic        dev_wr  [256] = '{default: 1'b0};
  int unsigned nstall = 0;
  int unsigned stall_q = 0;
  logic [7:0]  pcnt = '0;
  logic [42:0] snap = '0;
  logic        unstable = 1'b0;
  int          psel_hi = 0;
  rec_t        log_a [256];
  int          n_done = 0;

  assign pready  = psel & penable & (stall_q == 0);
  assign pslverr = pready & (paddr >= 10'h020) & (paddr < 10'h040);
  assign prdata  = dev_wr[paddr[9:2]] ? dev_mem[paddr[9:2]] : seed_val(paddr[9:2]);

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      stall_q <= 0;
      pcnt    <= '0;
    end else begin
      if (psel) psel_hi <= psel_hi + 1;
      if (psel && !penable) begin
        stall_q <= nstall;
        pcnt    <= 8'd1;
        snap    <= {paddr, pwrite, pwdata};
      end else if (psel && penable) begin
        if ({paddr, pwrite, pwdata} !== snap) unstable <= 1'b1;
        if (pready) begin
          log_a[n_done] <= '{addr: paddr, wr: pwrite, data: pwdata, cyc: pcnt + 8'd1};
          n_done <= n_done + 1;
          if (pwrite && !pslverr) begin
            dev_mem[paddr[9:2]] <= pwdata;
            dev_wr[paddr[9:2]]  <= 1'b1;
          end
          pcnt <= '0;
        end else begin
          stall_q <= stall_q - 1;
          pcnt    <= pcnt + 8'd1;
        end
      end
    end
  end

  // ---------------- model and checking ----------------
  logic [31:0] model_mem [256];
  rec_t        exp_q [$];
  int          rd_idx = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_apb();
    rec_t r, e;
    while (rd_idx < n_done) begin
      r = log_a[rd_idx];
      rd_idx++;
      if (exp_q.size() == 0) begin
        check("apb_unexpected_access", {22'd0, r.addr}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("apb_addr", {22'd0, r.addr}, {22'd0, e.addr});
        check("apb_write", {31'd0, r.wr}, {31'd0, e.wr});
        if (e.wr) check("apb_wdata", r.data, e.data);
        check("apb_psel_cycles", {24'd0, r.cyc}, {24'd0, e.cyc});
      end
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
    check_apb();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      hsel   = 1'($urandom);
      htrans = {1'b0, 1'($urandom)};
      hwrite = 1'($urandom);
      hsize  = 3'b010;
      haddr  = $urandom;
      tick();
      check("idle_hreadyout", {31'd0, hreadyout}, 32'd1);
      check("idle_hresp", {31'd0, hresp}, 32'd0);
      check("idle_hrdata", hrdata, 32'd0);
    end
  endtask

  // Drives the address phase in the current cycle, then follows the data phase
  // until hreadyout; returns inside the last data-phase cycle so calls pipeline.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                      input logic [31:0] wd, input int unsigned st);
    logic        legal, err;
    int unsigned exp_waits, waits;
    logic [31:0] exp_rd, pw_before;
    int          psel_before;
    legal     = (sz == 3'b010);
    err       = legal && (a[9:0] >= 10'h020) && (a[9:0] < 10'h040);
    exp_waits = !legal ? 1 : ((w ? 2 : 1) + st + (err ? 2 : 0));
    exp_rd    = (legal && !w && !err) ? model_mem[a[9:2]] : 32'd0;
    if (legal) begin
      exp_q.push_back('{addr: a[9:0], wr: w, data: wd, cyc: 8'(2 + st)});
      if (w && !err) model_mem[a[9:2]] = wd;
    end
    nstall = st;
    hsel = 1'b1; haddr = a; htrans = 2'b10; hwrite = w; hsize = sz;
    tick();
    pw_before   = pwdata;
    psel_before = psel_hi;
    hsel = 1'b0; htrans = 2'b00; haddr = $urandom; hwrite = 1'($urandom); hwdata = wd;
    waits = 0;
    while (hreadyout !== 1'b1 && waits < 40) begin
      waits++;
      tick();
    end
    check("wait_states", waits, exp_waits);
    check("hresp", {31'd0, hresp}, {31'd0, (err || !legal)});
    check("hrdata", hrdata, exp_rd);
    check("apb_stable_in_access", {31'd0, unstable}, 32'd0);
    if (!legal) begin
      check("illegal_pwdata_kept", pwdata, pw_before);
      check("illegal_no_psel", psel_hi - psel_before, 32'd0);
    end
  endtask

  initial begin
    int g;
    logic [31:0] a;
    logic [2:0]  sz;
    for (int i = 0; i < 256; i++) model_mem[i] = seed_val(8'(i));
    presetn = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'b010; hwdata = '0;
    #1;
    check("rst_psel", {31'd0, psel}, 32'd0);
    check("rst_penable", {31'd0, penable}, 32'd0);
    check("rst_pwrite", {31'd0, pwrite}, 32'd0);
    check("rst_paddr", {22'd0, paddr}, 32'd0);
    check("rst_pwdata", pwdata, 32'd0);
    check("rst_hreadyout", {31'd0, hreadyout}, 32'd1);
    check("rst_hresp", {31'd0, hresp}, 32'd0);
    check("rst_hrdata", hrdata, 32'd0);
    @(posedge pclk); @(posedge pclk); #1;
    presetn = 1'b1;
    idle(2);

    // write then read LCR
    xfer(32'h0C, 1'b1, 3'b010, 32'h1B, 0);
    check("lcr_pwdata", pwdata, 32'h1B);
    xfer(32'h0C, 1'b0, 3'b010, 32'h0, 0);
    idle(1);
    // invalid address -> APB error
    xfer(32'h20, 1'b0, 3'b010, 32'h0, 0);
    idle(1);
    // APB stall of 3 cycles
    xfer(32'h14, 1'b0, 3'b010, 32'h0, 3);
    idle(1);
    // back-to-back read then write
    xfer(32'h04, 1'b0, 3'b010, 32'h0, 0);
    xfer(32'h08, 1'b1, 3'b010, 32'hA5, 0);
    idle(1);
    // illegal size
    xfer(32'h18, 1'b1, 3'b000, 32'h77, 0);
    idle(1);

    // reset in the middle of ACCESS
    nstall = 5;
    hsel = 1'b1; haddr = 32'h10; htrans = 2'b10; hwrite = 1'b0; hsize = 3'b010;
    tick();
    hsel = 1'b0; htrans = 2'b00;
    g = 0;
    while (penable !== 1'b1 && g < 10) begin
      g++;
      tick();
    end
    check("reached_access", {31'd0, penable}, 32'd1);
    presetn = 1'b0;
    #1;
    check("midrst_psel", {31'd0, psel}, 32'd0);
    check("midrst_penable", {31'd0, penable}, 32'd0);
    check("midrst_hreadyout", {31'd0, hreadyout}, 32'd1);
    check("midrst_hresp", {31'd0, hresp}, 32'd0);
    tick();
    presetn = 1'b1;
    idle(1);
    xfer(32'h0C, 1'b0, 3'b010, 32'h0, 0);
    idle(1);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      a  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      sz = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 1)) : 3'b010;
      xfer(a, 1'($urandom), sz, $urandom, $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(3);
    check("apb_all_expected_seen", exp_q.size(), 32'd0);
    check("apb_no_extra_access", n_done - rd_idx, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
